req_mux: RTL and testbench

Parametrised N-way request multiplexer with registered output: arbitrates CH valid/ready input channels of width W onto one output channel through a single pipeline register. Generalises the 2:1 select mux to any channel count with flow control and fair arbitration. Sits in front of shared resources, e.g. instruction-fetch and data-access requests sharing one bus bridge.

---
 rtl/req_mux_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 67 ++++++
 rtl/req_mux.sv | 84 ++++++++
 tb/tb_req_mux.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/req_mux_pkg.sv
// req_mux shared helpers: index width and reset value of the
// round-robin pointer.
package req_mux_pkg;

  localparam int MIN_CH = 2;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Pointer resets to the last channel so channel 0 is served first.
  function automatic int rst_last(input int ch);
    return ch - 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter over CH requests. Round-robin when REQ_MUX_RR_EN
// is defined, otherwise fixed priority (lowest index wins).
import req_mux_pkg::*;

module rr_arbiter #(
  parameter int CH  = 2,
  parameter int CHW = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CH-1:0]  req_i,
  input  logic           advance_i,
  output logic [CH-1:0]  grant_o,
  output logic [CHW-1:0] idx_o
);

  logic found;

`ifdef REQ_MUX_RR_EN
  logic [CHW-1:0] last_q;
  logic [CHW-1:0] last_d;
  logic [CHW-1:0] cand;

  // Search order starts just after the last served channel.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= CH; k++) begin
      cand = CHW'((int'(last_q) + k) % CH);
      if (!found && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        found         = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance_i) last_d = idx_o;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= CHW'(rst_last(CH));
    else     last_q <= last_d;
  end
`else
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (!found && req_i[i]) begin
        grant_o[i] = 1'b1;
        idx_o      = CHW'(i);
        found      = 1'b1;
      end
    end
  end

  logic unused_fp;
  assign unused_fp = &{1'b0, clk, rst, advance_i};
`endif

endmodule

// File: rtl/req_mux.sv
// N-way valid/ready request mux with a single output register.
// Define REQ_MUX_RR_EN for round-robin arbitration.
import req_mux_pkg::*;

module req_mux #(
  parameter  int W   = 32,
  parameter  int CH  = 2,
  localparam int CHW = clog2_min1(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH*W-1:0] in_data,
  output logic [CH-1:0]   in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [CHW-1:0]  out_ch,
  input  logic            out_ready
);

  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [CHW-1:0] out_ch_q, out_ch_d;

  logic           load;
  logic           advance;
  logic [CH-1:0]  grant;
  logic [CHW-1:0] gidx;
  logic [W-1:0]   sel_data;

  rr_arbiter #(
    .CH  (CH),
    .CHW (CHW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (in_valid),
    .advance_i (advance),
    .grant_o   (grant),
    .idx_o     (gidx)
  );

  assign load     = !out_valid_q || out_ready;
  assign in_ready = grant & {CH{load & ~rst}};
  assign advance  = |in_ready;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant[i]) sel_data = in_data[i*W +: W];
    end
  end

  // A load with no grant drains the register but keeps payload/index.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (load) begin
      out_valid_d = |grant;
      if (|grant) begin
        out_data_d = sel_data;
        out_ch_d   = gidx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_req_mux.sv
// Directed bench for req_mux: a CH=2 instance for sequences and a
// CH=4 instance driven from a vector table.
module tb_req_mux;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst2, ordy2, ov2;
  logic [1:0]    iv2, ir2;
  logic [2*W-1:0] id2;
  logic [W-1:0]  od2;
  logic [0:0]    och2;

  logic          rst4, ordy4, ov4;
  logic [3:0]    iv4, ir4;
  logic [4*W-1:0] id4;
  logic [W-1:0]  od4;
  logic [1:0]    och4;

  req_mux #(.W(W), .CH(2)) d2 (
    .clk(clk), .rst(rst2), .in_valid(iv2), .in_data(id2),
    .in_ready(ir2), .out_valid(ov2), .out_data(od2),
    .out_ch(och2), .out_ready(ordy2)
  );

  req_mux #(.W(W), .CH(4)) d4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .in_data(id4),
    .in_ready(ir4), .out_valid(ov4), .out_data(od4),
    .out_ch(och4), .out_ready(ordy4)
  );

  typedef struct {
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  ch;
    logic [31:0] d;
  } vec_t;

  vec_t tbl [13];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Sample mid-cycle, then advance to just after the next edge.
  task automatic cyc2(input string tag, input logic [1:0] rdy,
                      input logic ov, input logic ch,
                      input logic [31:0] d);
    @(negedge clk);
    chk({tag, ".in_ready"},  32'(ir2),  32'(rdy));
    chk({tag, ".out_valid"}, 32'(ov2),  32'(ov));
    chk({tag, ".out_ch"},    32'(och2), 32'(ch));
    chk({tag, ".out_data"},  od2,       d);
    @(posedge clk); #1;
  endtask

  initial begin
    logic rr;
`ifdef REQ_MUX_RR_EN
    rr = 1'b1;
    tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h10};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 32'h21};
    tbl[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 32'h55};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 32'h33};
    tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd0, 32'h10};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 32'h55};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h55};
    tbl[9]  = '{4'b1010, 1'b0, 4'b1000, 1'b0, 2'd2, 32'h55};
    tbl[10] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'd3, 32'h33};
    tbl[11] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd3, 32'h33};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h21};
`else
    rr = 1'b0;
    tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h10};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h10};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h10};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h10};
    tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd0, 32'h10};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 32'h55};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h55};
    tbl[9]  = '{4'b1010, 1'b0, 4'b0010, 1'b0, 2'd2, 32'h55};
    tbl[10] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h21};
    tbl[11] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h21};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h21};
`endif

    rst2  = 1'b1;
    rst4  = 1'b1;
    iv2   = 2'b11;
    ordy2 = 1'b0;
    id2   = {32'hB, 32'hA};
    iv4   = 4'b0000;
    ordy4 = 1'b1;
    id4   = {32'h33, 32'h55, 32'h21, 32'h10};
    @(posedge clk); #1;

    // Reset state; valid inputs must not be accepted during reset.
    cyc2("rst", 2'b00, 1'b0, 1'b0, 32'h0);
    rst2  = 1'b0;
    ordy2 = 1'b1;
    cyc2("first", 2'b01, 1'b0, 1'b0, 32'h0);

    for (int k = 0; k < 4; k++) begin
      if (rr)
        cyc2($sformatf("alt%0d", k),
             (k % 2 == 0) ? 2'b10 : 2'b01, 1'b1,
             1'(k % 2), (k % 2 == 0) ? 32'hA : 32'hB);
      else
        cyc2($sformatf("fp%0d", k), 2'b01, 1'b1, 1'b0, 32'hA);
    end

    iv2 = 2'b01;
    id2 = {32'hB, 32'h1234};
    cyc2("s0", 2'b01, 1'b1, 1'b0, 32'hA);

    iv2   = 2'b11;
    ordy2 = 1'b0;
    id2   = {32'h5678, 32'h1234};
    for (int k = 0; k < 3; k++)
      cyc2($sformatf("stall%0d", k), 2'b00, 1'b1, 1'b0, 32'h1234);

    ordy2 = 1'b1;
    cyc2("release", rr ? 2'b10 : 2'b01, 1'b1, 1'b0, 32'h1234);
    iv2 = 2'b01;
    cyc2("refill", 2'b01, 1'b1, rr ? 1'b1 : 1'b0,
         rr ? 32'h5678 : 32'h1234);
    iv2   = 2'b11;
    ordy2 = 1'b0;
    cyc2("hold", 2'b00, 1'b1, 1'b0, 32'h1234);

    rst2 = 1'b1;
    cyc2("midrst", 2'b00, 1'b1, 1'b0, 32'h1234);
    rst2  = 1'b0;
    ordy2 = 1'b1;
    cyc2("postrst", 2'b01, 1'b0, 1'b0, 32'h0);
    iv2 = 2'b00;
    cyc2("postrst2", 2'b00, 1'b1, 1'b0, 32'h1234);

    rst4 = 1'b0;
    for (int r = 0; r < 13; r++) begin
      iv4   = tbl[r].iv;
      ordy4 = tbl[r].ordy;
      @(negedge clk);
      chk($sformatf("v%0d.in_ready", r),  32'(ir4),  32'(tbl[r].rdy));
      chk($sformatf("v%0d.out_valid", r), 32'(ov4),  32'(tbl[r].ov));
      chk($sformatf("v%0d.out_ch", r),    32'(och4), 32'(tbl[r].ch));
      chk($sformatf("v%0d.out_data", r),  od4,       tbl[r].d);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
